// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared CDB bus type and widths
// Falls back to a 4-bit NUM_SRBITS only when no define.vh has provided one.
`ifndef NUM_SRBITS
`define NUM_SRBITS 4
`endif

package cdb_arbiter_pkg;

  localparam int TAG_W  = `NUM_SRBITS;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_bus_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - FU result handshake and CDB broadcast signals
// master drives results/flush, slave is the arbiter.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = 4
) ();

  logic [NUM_FU-1:0]        fu_valid_i;
  logic [NUM_FU*TAG_W-1:0]  fu_tag_i;
  logic [NUM_FU*DATA_W-1:0] fu_data_i;
  logic [NUM_FU-1:0]        fu_ready_o;
  logic                     flush_i;
  cdb_bus_t                 cdb_o;
  logic [NUM_FU-1:0]        grant_o;

  modport master (
    output fu_valid_i, fu_tag_i, fu_data_i, flush_i,
    input  fu_ready_o, cdb_o, grant_o
  );

  modport slave (
    input  fu_valid_i, fu_tag_i, fu_data_i, flush_i,
    output fu_ready_o, cdb_o, grant_o
  );

endinterface

// File: rtl/cdb_result_fifo.sv
// rtl/cdb_result_fifo.sv - per-FU result queue of {tag, data}
// DEPTH must be a power of two so the pointers wrap naturally.
module cdb_result_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [TAG_W-1:0]  push_tag,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              ready,
  output logic              empty,
  output logic [TAG_W-1:0]  head_tag,
  output logic [DATA_W-1:0] head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign ready     = (count < CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && ready && !flush;
  assign do_pop    = pop && !empty && !flush;
  assign head_tag  = tag_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      tag_mem[wr_ptr]  <= push_tag;
      data_mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - common data bus arbiter over per-FU result queues
// CDB_ROUND_ROBIN_EN selects round-robin grant; default is fixed lowest-index priority.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = 4,
  parameter int DEPTH  = 2
) (
  input  logic         clk,
  input  logic         rst,
  cdb_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0] ready;
  logic [NUM_FU-1:0] empty;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] grant;
  logic [TAG_W-1:0]  head_tag  [NUM_FU];
  logic [DATA_W-1:0] head_data [NUM_FU];
  logic              any_ready_q;
  logic              bcast;
  logic [IDX_W-1:0]  grant_idx;
  cdb_bus_t          cdb;

  for (genvar k = 0; k < NUM_FU; k++) begin : g_fu
    // Tag 0 completes the handshake but never enters the queue.
    assign push[k] = bus.fu_valid_i[k] && ready[k] && !bus.flush_i &&
                     (bus.fu_tag_i[k*TAG_W +: TAG_W] != '0);

    cdb_result_fifo #(
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (bus.flush_i),
      .push     (push[k]),
      .push_tag (bus.fu_tag_i[k*TAG_W +: TAG_W]),
      .push_data(bus.fu_data_i[k*DATA_W +: DATA_W]),
      .pop      (grant[k]),
      .ready    (ready[k]),
      .empty    (empty[k]),
      .head_tag (head_tag[k]),
      .head_data(head_data[k])
    );
  end

`ifdef CDB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr;

  // Pointer holds across flush cycles because bcast is masked then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (bcast) begin
      rr_ptr <= (int'(grant_idx) == NUM_FU - 1) ? '0 : grant_idx + IDX_W'(1);
    end
  end
`endif

  always_comb begin
    int idx;
    any_ready_q = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int i = 0; i < NUM_FU; i++) begin
`ifdef CDB_ROUND_ROBIN_EN
      idx = (int'(rr_ptr) + i) % NUM_FU;
`else
      idx = i;
`endif
      if (!any_ready_q && !empty[idx]) begin
        any_ready_q = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
  end

  assign bcast = any_ready_q && !bus.flush_i;

  always_comb begin
    cdb   = '0;
    grant = '0;
    if (bcast) begin
      cdb.valid        = 1'b1;
      cdb.tag          = head_tag[grant_idx];
      cdb.data         = head_data[grant_idx];
      grant[grant_idx] = 1'b1;
    end
  end

  assign bus.cdb_o      = cdb;
  assign bus.grant_o    = grant;
  assign bus.fu_ready_o = ready;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NF    = 4;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_FU(NF)) bus ();

  cdb_arbiter #(
    .NUM_FU(NF),
    .DEPTH (DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic idle();
    bus.fu_valid_i = '0;
    bus.fu_tag_i   = '0;
    bus.fu_data_i  = '0;
    bus.flush_i    = 1'b0;
  endtask

  task automatic drive(input int k, input int tag, input logic [31:0] data);
    bus.fu_valid_i[k]                = 1'b1;
    bus.fu_tag_i[k*TAG_W +: TAG_W]   = TAG_W'(tag);
    bus.fu_data_i[k*32 +: 32]        = data;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    cdb_bus_t zero_bus;
    zero_bus = '0;
    idle();
    #1;
    tests++;
    if (bus.cdb_o !== zero_bus) begin
      failed++; $display("FAIL reset_cdb got=%h exp=%h", bus.cdb_o, zero_bus);
    end
    tests++;
    if (bus.grant_o !== 4'b0000) begin
      failed++; $display("FAIL reset_grant got=%b exp=0000", bus.grant_o);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (bus.fu_ready_o !== 4'b1111) begin
      failed++; $display("FAIL reset_ready got=%b exp=1111", bus.fu_ready_o);
    end
    tests++;
    if (bus.cdb_o.valid !== 1'b0) begin
      failed++; $display("FAIL reset_valid_after got=%b exp=0", bus.cdb_o.valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    idle();
    drive(1, 3, 32'hDEAD_BEEF);
    #1;
    tests++;
    if (bus.cdb_o.valid !== 1'b0) begin
      failed++; $display("FAIL single_no_bypass got=%b exp=0", bus.cdb_o.valid);
    end
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (bus.cdb_o.valid !== 1'b1 || bus.cdb_o.tag !== TAG_W'(3) ||
        bus.cdb_o.data !== 32'hDEAD_BEEF || bus.grant_o !== 4'b0010) begin
      failed++;
      $display("FAIL single_bcast got=%b/%0d/%h/%b exp=1/3/deadbeef/0010",
               bus.cdb_o.valid, bus.cdb_o.tag, bus.cdb_o.data, bus.grant_o);
    end
    @(negedge clk);
    #1;
    tests++;
    if (bus.cdb_o.valid !== 1'b0 || bus.grant_o !== 4'b0000) begin
      failed++; $display("FAIL single_after got=%b/%b exp=0/0000", bus.cdb_o.valid, bus.grant_o);
    end
  endtask

  task automatic test_contention();
    do_reset();
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      idle();
      for (int k = 0; k < NF; k++) drive(k, b*4 + k + 1, 32'h100 + 32'(b*4 + k));
      #1;
      tests++;
      if (bus.cdb_o.valid !== 1'b0) begin
        failed++; $display("FAIL cont_no_bypass burst=%0d got=%b exp=0", b, bus.cdb_o.valid);
      end
      for (int c = 0; c < NF; c++) begin
        logic [3:0] exp_g;
        exp_g = 4'b0001 << c;
        @(negedge clk);
        idle();
        #1;
        tests++;
        if (bus.cdb_o.valid !== 1'b1 || bus.cdb_o.tag !== TAG_W'(b*4 + c + 1) ||
            bus.cdb_o.data !== 32'h100 + 32'(b*4 + c) || bus.grant_o !== exp_g) begin
          failed++;
          $display("FAIL cont_bcast burst=%0d slot=%0d got=%b/%0d/%h/%b exp=1/%0d/%h/%b",
                   b, c, bus.cdb_o.valid, bus.cdb_o.tag, bus.cdb_o.data, bus.grant_o,
                   b*4 + c + 1, 32'h100 + 32'(b*4 + c), exp_g);
        end
      end
      @(negedge clk);
      #1;
      tests++;
      if (bus.cdb_o.valid !== 1'b0 || bus.grant_o !== 4'b0000) begin
        failed++; $display("FAIL cont_drain burst=%0d got=%b/%b exp=0/0000", b, bus.cdb_o.valid, bus.grant_o);
      end
    end
  endtask

  task automatic test_order();
    int         exp_t [3];
    logic [3:0] exp_g [3];
`ifdef CDB_ROUND_ROBIN_EN
    exp_t = '{1, 5, 2};
    exp_g = '{4'b0001, 4'b0010, 4'b0001};
`else
    exp_t = '{1, 2, 5};
    exp_g = '{4'b0001, 4'b0001, 4'b0010};
`endif
    do_reset();
    @(negedge clk);
    idle();
    drive(0, 1, 32'h11);
    drive(1, 5, 32'h55);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      idle();
      if (c == 0) drive(0, 2, 32'h22);
      #1;
      tests++;
      if (c < 3) begin
        if (bus.cdb_o.valid !== 1'b1 || bus.cdb_o.tag !== TAG_W'(exp_t[c]) || bus.grant_o !== exp_g[c]) begin
          failed++;
          $display("FAIL order slot=%0d got=%b/%0d/%b exp=1/%0d/%b",
                   c, bus.cdb_o.valid, bus.cdb_o.tag, bus.grant_o, exp_t[c], exp_g[c]);
        end
      end else if (bus.cdb_o.valid !== 1'b0) begin
        failed++; $display("FAIL order_drain got=%b exp=0", bus.cdb_o.valid);
      end
    end
  endtask

`ifndef CDB_ROUND_ROBIN_EN
  task automatic test_fixed_contention();
    int         exp_t [7] = '{0, 1, 2, 3, 4, 9, 0};
    logic [3:0] exp_g [7] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0000};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      idle();
      if (c < 4)  drive(0, c + 1, 32'(c));
      if (c == 0) drive(2, 9, 32'h99);
      #1;
      if (c >= 1) begin
        tests++;
        if (bus.cdb_o.valid !== (exp_t[c] != 0) || bus.grant_o !== exp_g[c] ||
            (exp_t[c] != 0 && bus.cdb_o.tag !== TAG_W'(exp_t[c]))) begin
          failed++;
          $display("FAIL fixed_cont cycle=%0d got=%b/%0d/%b exp=%0d/%0d/%b",
                   c, bus.cdb_o.valid, bus.cdb_o.tag, bus.grant_o, exp_t[c] != 0, exp_t[c], exp_g[c]);
        end
      end
    end
  endtask

  task automatic test_full();
    logic       exp_r [9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
    int         exp_t [9] = '{0, 1, 2, 3, 11, 12, 0, 14, 0};
    logic [3:0] exp_g [9] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b1000, 4'b1000,
                              4'b0000, 4'b1000, 4'b0000};
    do_reset();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      idle();
      if (c < 3)  drive(0, c + 1, 32'(c));
      if (c < 3)  drive(3, 11 + c, 32'h300 + 32'(c));
      if (c == 6) drive(3, 14, 32'h314);
      #1;
      tests++;
      if (bus.fu_ready_o[3] !== exp_r[c]) begin
        failed++; $display("FAIL full_ready3 cycle=%0d got=%b exp=%b", c, bus.fu_ready_o[3], exp_r[c]);
      end
      tests++;
      if (bus.cdb_o.valid !== (exp_t[c] != 0) || bus.grant_o !== exp_g[c] ||
          (exp_t[c] != 0 && bus.cdb_o.tag !== TAG_W'(exp_t[c]))) begin
        failed++;
        $display("FAIL full_bcast cycle=%0d got=%b/%0d/%b exp=%0d/%0d/%b",
                 c, bus.cdb_o.valid, bus.cdb_o.tag, bus.grant_o, exp_t[c] != 0, exp_t[c], exp_g[c]);
      end
    end
  endtask
`endif

  task automatic test_flush();
    do_reset();
    @(negedge clk);
    idle();
    drive(0, 1, 32'hA1);
    drive(2, 2, 32'hA2);
    drive(3, 3, 32'hA3);
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (bus.cdb_o.valid !== 1'b1 || bus.cdb_o.tag !== TAG_W'(1)) begin
      failed++; $display("FAIL flush_pre got=%b/%0d exp=1/1", bus.cdb_o.valid, bus.cdb_o.tag);
    end
    @(negedge clk);
    bus.flush_i = 1'b1;
    drive(1, 7, 32'h77);
    #1;
    tests++;
    if (bus.cdb_o.valid !== 1'b0 || bus.grant_o !== 4'b0000) begin
      failed++; $display("FAIL flush_cycle got=%b/%b exp=0/0000", bus.cdb_o.valid, bus.grant_o);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      idle();
      #1;
      tests++;
      if (bus.cdb_o.valid !== 1'b0 || bus.grant_o !== 4'b0000) begin
        failed++; $display("FAIL flush_after cycle=%0d got=%b/%0d/%b exp=0/-/0000",
                           c, bus.cdb_o.valid, bus.cdb_o.tag, bus.grant_o);
      end
    end
    tests++;
    if (bus.fu_ready_o !== 4'b1111) begin
      failed++; $display("FAIL flush_ready got=%b exp=1111", bus.fu_ready_o);
    end
  endtask

  task automatic test_tag0();
    do_reset();
    @(negedge clk);
    idle();
    drive(2, 0, 32'h1234);
    #1;
    tests++;
    if (bus.fu_ready_o[2] !== 1'b1) begin
      failed++; $display("FAIL tag0_ready got=%b exp=1", bus.fu_ready_o[2]);
    end
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (bus.cdb_o.valid !== 1'b0 || bus.grant_o !== 4'b0000) begin
      failed++; $display("FAIL tag0_no_bcast got=%b/%b exp=0/0000", bus.cdb_o.valid, bus.grant_o);
    end
    drive(2, 6, 32'h66);
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (bus.cdb_o.valid !== 1'b1 || bus.cdb_o.tag !== TAG_W'(6) || bus.grant_o !== 4'b0100) begin
      failed++; $display("FAIL tag0_then_real got=%b/%0d/%b exp=1/6/0100",
                         bus.cdb_o.valid, bus.cdb_o.tag, bus.grant_o);
    end
  endtask

  task automatic test_reset_mid();
    cdb_bus_t zero_bus;
    zero_bus = '0;
    do_reset();
    @(negedge clk);
    idle();
    drive(0, 1, 32'hB1);
    drive(1, 2, 32'hB2);
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (bus.cdb_o.valid !== 1'b1 || bus.cdb_o.tag !== TAG_W'(1)) begin
      failed++; $display("FAIL rstmid_pre got=%b/%0d exp=1/1", bus.cdb_o.valid, bus.cdb_o.tag);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (bus.cdb_o !== zero_bus || bus.grant_o !== 4'b0000) begin
      failed++; $display("FAIL rstmid_async got=%h/%b exp=0/0000", bus.cdb_o, bus.grant_o);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      tests++;
      if (bus.cdb_o.valid !== 1'b0 || bus.fu_ready_o !== 4'b1111) begin
        failed++; $display("FAIL rstmid_after cycle=%0d got=%b/%b exp=0/1111",
                           c, bus.cdb_o.valid, bus.fu_ready_o);
      end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_single();
    test_contention();
    test_order();
`ifndef CDB_ROUND_ROBIN_EN
    test_fixed_contention();
    test_full();
`endif
    test_flush();
    test_tag0();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_FU, default 4, number of functional-unit result sources.
REQ-002 SHALL have parameter DEPTH, default 2, result-queue entries per FU (power of two, >=2).
REQ-003 SHALL have port clk  input  1  clock, rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port fu_valid_i  input  NUM_FU  per-FU result valid.
REQ-006 SHALL have port fu_tag_i  input  NUM_FU*`NUM_SRBITS  per-FU reservation-station tag, FU k at slice k.
REQ-007 SHALL have port fu_data_i  input  NUM_FU*32  per-FU result value, FU k at slice k.
REQ-008 SHALL have port fu_ready_o  output  NUM_FU  per-FU queue can accept.
REQ-009 SHALL have port flush_i  input  1  misprediction restore; discard all pending results.
REQ-010 SHALL have port cdb_o  output  cdb_bus_t (valid, tag, data)  common data bus broadcast.
REQ-011 SHALL have port grant_o  output  NUM_FU  one-hot FU currently broadcasting.

Function
REQ-012 SHALL keep one FIFO of DEPTH entries {tag, data} per FU.
REQ-013 SHALL assert fu_ready_o[k] iff queue k count < DEPTH; no credit is given for a same-cycle pop.
REQ-014 SHALL enqueue on fu_valid_i[k] && fu_ready_o[k] at the rising edge; valid while not ready SHALL be ignored.
REQ-015 SHALL accept a result carrying tag 0 (handshake completes) but discard it; tag 0 is never broadcast.
REQ-016 SHALL drive cdb_o combinationally from the head of exactly one non-empty queue per cycle; that head pops at the cycle's edge.
REQ-017 SHALL have latency one: a result accepted at edge n is broadcastable in cycle n+1 at earliest; no same-cycle bypass.
REQ-018 SHALL drive cdb_o.valid=0, tag=0, data=0, grant_o=0 when all queues are empty.
REQ-019 SHALL preserve per-FU order; broadcast order across FUs follows arbitration.
REQ-020 SHALL allow simultaneous push and pop on the same queue, count unchanged.
REQ-021 SHALL wrap FIFO read/write pointers modulo DEPTH.
REQ-022 SHALL on flush_i clear all queues at that edge, drop same-cycle enqueues, hold the arbitration pointer, and force cdb_o.valid=0 and grant_o=0 during the flush cycle.

Reset
REQ-023 SHALL on rst empty all queues, set arbitration pointer to FU 0, drive fu_ready_o all ones once rst deasserts, and cdb_o/grant_o zero throughout.
REQ-024 SHALL abort in-flight results on reset mid-operation with no broadcast of them afterward.

Configuration
REQ-025 With CDB_ROUND_ROBIN_EN defined, SHALL grant the first non-empty queue at or after pointer, pointer advancing to granted index+1 (mod NUM_FU) after each grant.
REQ-026 Without CDB_ROUND_ROBIN_EN, SHALL grant the lowest-index non-empty queue; pointer logic SHALL be absent.

Structure
REQ-027 cdb_bus_t and `NUM_SRBITS SHALL come from the shared package/define.vh; no local redefinition.
REQ-028 SHALL instantiate sub-module cdb_result_fifo (one per FU) holding queue storage, pointers, count.

Verification
REQ-029 Single FU: FU1 sends tag 3, data 0xDEAD_BEEF at edge 0 -> cdb_o {1,3,0xDEADBEEF}, grant_o=0010 in cycle 1 only.
REQ-030 Contention (RR): FU0-FU3 all valid same edge, tags 1-4 -> broadcasts tags 1,2,3,4 on consecutive cycles; next burst starts at FU0 after pointer wrap.
REQ-031 Contention (fixed): FU0 continuous, FU2 one result -> FU2 waits until FU0 queue empties; no loss.
REQ-032 Full: FU0 pushes DEPTH results while broadcast blocked by FU... (fixed priority, FU0 blocked by nothing) -> use FU3 under fixed priority with FU0 saturating: fu_ready_o[3]=0 after 2 pushes, third valid ignored, then resumes.
REQ-033 Flush: 3 queued results, flush_i at edge 5 with FU1 pushing tag 7 -> cdb_o.valid=0 in cycle 5 and after; tag 7 never broadcast.
REQ-034 Tag-0 and reset: FU2 pushes tag 0 -> no broadcast; rst asserted with 2 queued -> cdb_o zero immediately, queues empty after release.
